// File: rtl/spi_init_pkg.sv
// ============================================================
// spi_init_pkg : entry layout, device codes, default init table
// and sequence descriptors for spi_init_sequencer.
// Revision: 1.0
// ============================================================
`default_nettype none

package spi_init_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = BYTE_W + 2;
  localparam int EOF_BIT = BYTE_W;
  localparam int EOS_BIT = BYTE_W + 1;

  localparam logic DEV_ADC = 1'b0;
  localparam logic DEV_MCP = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES = 1000;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef struct packed {
    logic [7:0] start_addr;
    logic       dev;
  } seq_desc_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] F_MID = 2'b00;
  localparam logic [1:0] F_EOF = 2'b01;
  localparam logic [1:0] F_EOS = 2'b11;

  // Entry = {eos, eof, byte}; the end of a sequence always closes its frame.
  function automatic entry_t default_rom(input int unsigned addr);
    case (addr)
      0:  return {F_MID, 8'h03};
      1:  return {F_MID, 8'h00};
      2:  return {F_MID, 8'h00};
      3:  return {F_EOF, 8'h80};
      4:  return {F_MID, 8'h03};
      5:  return {F_MID, 8'h00};
      6:  return {F_MID, 8'h00};
      7:  return {F_EOS, 8'h00};
      8:  return {F_MID, 8'h40};
      9:  return {F_MID, 8'h00};
      10: return {F_EOF, 8'h00};
      11: return {F_MID, 8'h40};
      12: return {F_MID, 8'h01};
      13: return {F_EOF, 8'h00};
      14: return {F_MID, 8'h40};
      15: return {F_MID, 8'h13};
      16: return {F_EOS, 8'h00};
      17: return {F_MID, 8'h40};
      18: return {F_MID, 8'h12};
      19: return {F_EOS, 8'h01};
      20: return {F_MID, 8'h40};
      21: return {F_MID, 8'h12};
      22: return {F_EOS, 8'h00};
      default: return '0;
    endcase
  endfunction

  function automatic seq_desc_t seq_desc(input int unsigned idx);
    case (idx)
      0: return '{start_addr: 8'd0,  dev: DEV_ADC};
      1: return '{start_addr: 8'd8,  dev: DEV_MCP};
      2: return '{start_addr: 8'd17, dev: DEV_MCP};
      3: return '{start_addr: 8'd20, dev: DEV_MCP};
      default: return '{start_addr: 8'd0, dev: DEV_ADC};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_init_rom.sv
// ============================================================
// spi_init_rom : registered init-table read plus combinational
// sequence descriptor decode.
// Revision: 1.0
// ============================================================
`default_nettype none

module spi_init_rom
  import spi_init_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ROM_DEPTH = 32,
  parameter int ADDR_W    = 5,
  parameter int N_SEQ     = 4,
  parameter int SEQ_W     = 2,
  parameter int DEV_W     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SEQ_W-1:0]  seq_sel_i,
  output logic [DATA_W-1:0] data_o,
  output logic              eof_o,
  output logic              eos_o,
  output logic [ADDR_W-1:0] desc_addr_o,
  output logic [DEV_W-1:0]  desc_dev_o,
  output logic              desc_valid_o
);

  entry_t    w_entry;
  seq_desc_t w_desc;

  assign w_entry = (int'(addr_i) < ROM_DEPTH) ? default_rom(int'(addr_i)) : '0;
  assign w_desc  = seq_desc(int'(seq_sel_i));

  assign desc_valid_o = int'(seq_sel_i) < N_SEQ;
  assign desc_addr_o  = ADDR_W'(w_desc.start_addr);
  assign desc_dev_o   = DEV_W'(w_desc.dev);

  // Output register only moves on a read so a stalled byte stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
      eof_o  <= 1'b0;
      eos_o  <= 1'b0;
    end else if (rd_en_i) begin
      data_o <= DATA_W'(w_entry[BYTE_W-1:0]);
      eof_o  <= w_entry[EOF_BIT];
      eos_o  <= w_entry[EOS_BIT];
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_init_sequencer.sv
// ============================================================
// spi_init_sequencer : streams a selected SPI init sequence to a
// byte master with cs_n framing and inter-frame gaps.
// Optional: define SPI_TX_TIMEOUT_EN to abort a stalled SEND.
// Revision: 1.0
// ============================================================
`default_nettype none

module spi_init_sequencer
  import spi_init_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ROM_DEPTH  = 32,
  parameter int ADDR_W     = 5,
  parameter int N_SEQ      = 4,
  parameter int SEQ_W      = 2,
  parameter int GAP_CYCLES = 4,
  parameter int DEV_W      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEQ_W-1:0]  seq_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              cs_n,
  output logic [DEV_W-1:0]  dev_sel
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DEV_W-1:0]  dev_q, dev_d;
  logic              err_q, err_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rd_en;
  logic [DATA_W-1:0] rom_data;
  logic              rom_eof, rom_eos;
  logic [ADDR_W-1:0] desc_addr;
  logic [DEV_W-1:0]  desc_dev;
  logic              desc_valid;

  spi_init_rom #(
    .DATA_W    (DATA_W),
    .ROM_DEPTH (ROM_DEPTH),
    .ADDR_W    (ADDR_W),
    .N_SEQ     (N_SEQ),
    .SEQ_W     (SEQ_W),
    .DEV_W     (DEV_W)
  ) u_rom (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (rd_en),
    .addr_i       (addr_q),
    .seq_sel_i    (seq_sel),
    .data_o       (rom_data),
    .eof_o        (rom_eof),
    .eos_o        (rom_eos),
    .desc_addr_o  (desc_addr),
    .desc_dev_o   (desc_dev),
    .desc_valid_o (desc_valid)
  );

`ifdef SPI_TX_TIMEOUT_EN
  logic [15:0] to_q;
  logic        to_hit;

  assign to_hit = (to_q == 16'(TIMEOUT_CYCLES - 1)) && !tx_ready;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_SEND || tx_ready) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + 16'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dev_d   = dev_q;
    err_d   = err_q;
    gap_d   = gap_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (desc_valid) begin
            addr_d  = desc_addr;
            dev_d   = desc_dev;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        rd_en   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (rom_eos) begin
            state_d = S_DONE;
          end else if (addr_q == LAST_ADDR) begin
            // Table would run off its end: terminate as an error.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (rom_eof) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
`ifdef SPI_TX_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == '0) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dev_q   <= '0;
      err_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dev_q   <= dev_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done && err_q;
  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = tx_valid ? rom_data : '0;
  assign tx_last  = tx_valid && rom_eof;
  assign cs_n     = !((state_q == S_LOAD) || (state_q == S_SEND));
  assign dev_sel  = dev_q;

endmodule

`default_nettype wire
